// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared types and constants for the SME character feeder
package sme_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKIP,
        ST_EMIT,
        ST_WAIT_RES
    } state_e;

    typedef enum logic {
        REC_STRING,
        REC_PATTERN
    } rec_e;

    localparam logic [7:0] TAG_S = 8'h53;
    localparam logic [7:0] TAG_P = 8'h50;
    localparam logic [7:0] NL    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;

    // States in which the host byte stream is being consumed.
    function automatic logic accepts_input(input state_e s);
        return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_SKIP);
    endfunction

endpackage

// File: rtl/sme_line_buf.sv
// rtl/sme_line_buf.sv - line buffer with write/length counter and replay read pointer
module sme_line_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    input  logic          adv_i,
    output logic [AW:0]   len_o,
    output logic [7:0]    first_data_o,
    output logic [7:0]    next_data_o,
    output logic          last_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   len_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_next;

    assign rd_next      = rd_ptr_q + AW'(1);
    assign len_o        = len_q;
    assign first_data_o = mem_q[0];
    assign next_data_o  = mem_q[rd_next];
    // rd_ptr_q always names the char currently on the output; it never passes len-1.
    assign last_o       = ({1'b0, rd_ptr_q} == (len_q - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            len_q    <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                len_q <= len_q + (AW+1)'(1);
            end
            if (adv_i) begin
                rd_ptr_q <= rd_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[len_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sme_char_feeder.sv
// rtl/sme_char_feeder.sv - frames host lines into gap-free string/pattern char bursts for the SME
module sme_char_feeder
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int AW      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       sme_valid,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    output logic       busy,
    output logic       err_ovf,
    output logic       err_tag
);

    state_e     state_q, state_d;
    rec_e       rtype_q, rtype_d;
    logic       ovf_q, ovf_d;
    logic       in_ready_q;
    logic       busy_q;
    logic [7:0] chardata_q, chardata_d;
    logic       isstring_q, isstring_d;
    logic       ispattern_q, ispattern_d;
    logic       err_ovf_q, err_ovf_d;
    logic       err_tag_q, err_tag_d;

    logic        hs;
    logic        buf_clear, buf_wr, buf_adv;
    logic [AW:0] buf_len;
    logic [AW:0] limit;
    logic [7:0]  first_data, next_data;
    logic        buf_last;

    sme_line_buf #(
        .DEPTH (STR_MAX),
        .AW    (AW)
    ) u_line_buf (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (buf_clear),
        .wr_en_i      (buf_wr),
        .wr_data_i    (in_data),
        .adv_i        (buf_adv),
        .len_o        (buf_len),
        .first_data_o (first_data),
        .next_data_o  (next_data),
        .last_o       (buf_last)
    );

    assign hs    = in_valid & in_ready_q;
    assign limit = (rtype_q == REC_PATTERN) ? (AW+1)'(PAT_MAX) : (AW+1)'(STR_MAX);

    always_comb begin
        state_d     = state_q;
        rtype_d     = rtype_q;
        ovf_d       = ovf_q;
        chardata_d  = chardata_q;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        err_ovf_d   = 1'b0;
        err_tag_d   = 1'b0;
        buf_clear   = 1'b0;
        buf_wr      = 1'b0;
        buf_adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (in_data == TAG_S || in_data == TAG_P) begin
                        state_d   = ST_LOAD;
                        rtype_d   = (in_data == TAG_P) ? REC_PATTERN : REC_STRING;
                        ovf_d     = 1'b0;
                        buf_clear = 1'b1;
                    end else if (in_data != NL && in_data != CR) begin
                        state_d   = ST_SKIP;
                        err_tag_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    if (in_data == NL) begin
                        ovf_d = 1'b0;
                        if (buf_len == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            // First char is presented straight off the newline handshake.
                            state_d     = ST_EMIT;
                            err_ovf_d   = ovf_q;
                            chardata_d  = first_data;
                            isstring_d  = (rtype_q == REC_STRING);
                            ispattern_d = (rtype_q == REC_PATTERN);
                        end
                    end else if (in_data != CR) begin
                        if (buf_len < limit) begin
                            buf_wr = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            ST_SKIP: begin
                if (hs && in_data == NL) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (buf_last) begin
                    state_d = (rtype_q == REC_STRING) ? ST_IDLE : ST_WAIT_RES;
                end else begin
                    buf_adv     = 1'b1;
                    chardata_d  = next_data;
                    isstring_d  = (rtype_q == REC_STRING);
                    ispattern_d = (rtype_q == REC_PATTERN);
                end
            end
            ST_WAIT_RES: begin
                if (sme_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rtype_q     <= REC_STRING;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            chardata_q  <= 8'h00;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_tag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rtype_q     <= rtype_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= accepts_input(state_d);
            busy_q      <= (state_d != ST_IDLE);
            chardata_q  <= chardata_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            err_ovf_q   <= err_ovf_d;
            err_tag_q   <= err_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign chardata  = chardata_q;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign err_ovf   = err_ovf_q;
    assign err_tag   = err_tag_q;

endmodule

// File: tb/tb_sme_char_feeder.sv
// tb/tb_sme_char_feeder.sv - scoreboard bench for sme_char_feeder with line-level reference model
module tb_sme_char_feeder;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam logic [7:0] C_NL = 8'h0A;
    localparam logic [7:0] C_CR = 8'h0D;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic       is_p;
        logic [7:0] ch;
        logic       first;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sme_valid;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       busy;
    logic       err_ovf;
    logic       err_tag;

    exp_t chars_q[$];
    int   err_q[$];
    int   tests = 0;
    int   fails = 0;
    int   resp_delay = 3;
    int   wait_st = 0;

    bit   mon_pending = 0;
    bit   mon_post_s = 0;
    int   mon_resp_cnt = 0;

    always #5 clk = ~clk;

    sme_char_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sme_valid (sme_valid),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .busy      (busy),
        .err_ovf   (err_ovf),
        .err_tag   (err_tag)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference model: what one complete host line should produce.
    task automatic model_line(input bq_t line);
        int i = 0;
        logic [7:0] tag;
        bq_t payload;
        int limit, kept;
        exp_t e;
        while (i < line.size() && (line[i] == C_NL || line[i] == C_CR)) i++;
        if (i >= line.size()) return;
        tag = line[i];
        i++;
        if (tag == "S" || tag == "P") begin
            for (int j = i; j < line.size(); j++) begin
                if (line[j] == C_NL) break;
                if (line[j] != C_CR) payload.push_back(line[j]);
            end
            limit = (tag == "P") ? PAT_MAX : STR_MAX;
            kept = (payload.size() > limit) ? limit : payload.size();
            for (int k = 0; k < kept; k++) begin
                e.is_p  = (tag == "P");
                e.ch    = payload[k];
                e.first = (k == 0);
                e.last  = (k == kept - 1);
                chars_q.push_back(e);
            end
            if (payload.size() > limit && kept > 0) err_q.push_back(1);
        end else begin
            err_q.push_back(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
            $fatal(1, "stuck");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue_line(input bq_t line);
        model_line(line);
        foreach (line[i]) send_byte(line[i]);
    endtask

    task automatic wait_quiet();
        int t = 0;
        while (t < 3000 && !(chars_q.size() == 0 && err_q.size() == 0 && wait_st == 0
                             && !busy && !isstring && !ispattern)) begin
            @(negedge clk);
            t++;
        end
        check("quiet_reached", (t < 3000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_isstring"}, isstring, 0);
        check({tag, "_ispattern"}, ispattern, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // Monitor: pops the scoreboard on every emitted char and plays the SME side.
    initial begin
        exp_t e;
        bit this_first;
        sme_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mon_pending = 0;
                mon_post_s  = 0;
                wait_st     = 0;
                sme_valid   = 1'b0;
            end else begin
                this_first = 0;
                if (mon_post_s) begin
                    check("after_s_in_ready", in_ready, 1);
                    check("after_s_busy", busy, 0);
                    mon_post_s = 0;
                end
                if (wait_st == 2) begin
                    sme_valid = 1'b0;
                    check("resp_in_ready", in_ready, 1);
                    check("resp_busy", busy, 0);
                    wait_st = 0;
                end else if (wait_st == 1) begin
                    sme_valid = 1'b0;
                    check("wait_in_ready", in_ready, 0);
                    if (mon_resp_cnt == 0) begin
                        sme_valid = 1'b1;
                        wait_st = 2;
                    end else begin
                        mon_resp_cnt--;
                    end
                end
                if (isstring && ispattern) check("flags_exclusive", 1, 0);
                if (isstring || ispattern) begin
                    check("emit_in_ready", in_ready, 0);
                    if (chars_q.size() == 0) begin
                        check("unexpected_char", chardata, -1);
                        mon_pending = 0;
                    end else begin
                        e = chars_q.pop_front();
                        this_first = e.first;
                        check("char_type_p", ispattern, int'(e.is_p));
                        check("char_value", chardata, int'(e.ch));
                        if (e.last) begin
                            mon_pending = 0;
                            if (e.is_p) begin
                                // Strobe during the last char must be ignored by the feeder.
                                sme_valid = 1'b1;
                                wait_st = 1;
                                mon_resp_cnt = resp_delay;
                            end else begin
                                mon_post_s = 1;
                            end
                        end else begin
                            mon_pending = 1;
                        end
                    end
                end else if (mon_pending) begin
                    check("emit_gap", 0, 1);
                    mon_pending = 0;
                end
                if (err_ovf) begin
                    check("ovf_with_first", int'(this_first), 1);
                    if (err_q.size() == 0) check("unexpected_err_ovf", 1, 0);
                    else check("err_kind_ovf", err_q.pop_front(), 1);
                end
                if (err_tag) begin
                    if (err_q.size() == 0) check("unexpected_err_tag", 1, 0);
                    else check("err_kind_tag", err_q.pop_front(), 2);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time got %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t line;
        int t;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_chardata", chardata, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_tag", err_tag, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        issue_line(str2q("Shello\n"));
        wait_quiet();

        resp_delay = 20;
        issue_line(str2q("Pab\n"));
        wait_quiet();
        resp_delay = 3;

        line = {"S"};
        for (int i = 0; i < 40; i++) line.push_back(8'h61 + 8'(i % 26));
        line.push_back(C_NL);
        issue_line(line);
        line = {"P"};
        for (int i = 0; i < 10; i++) line.push_back(8'h30 + 8'(i));
        line.push_back(C_NL);
        issue_line(line);
        wait_quiet();

        issue_line(str2q("X12\n"));
        issue_line(str2q("Sab\n"));
        issue_line(str2q("S\n"));
        issue_line(str2q("\r\n"));
        issue_line(str2q("Sa\r\n"));
        wait_quiet();

        for (int n = 0; n < 30; n++) begin
            int kind, plen;
            if (n % 10 == 0) begin
                wait_quiet();
                resp_delay = $urandom_range(0, 4);
            end
            kind = $urandom_range(0, 9);
            line = {};
            if (kind < 5) begin
                line.push_back("S");
                plen = $urandom_range(0, 40);
            end else if (kind < 8) begin
                line.push_back("P");
                plen = $urandom_range(0, 12);
            end else begin
                line.push_back(8'h41 + 8'($urandom_range(0, 14)));
                plen = $urandom_range(0, 6);
            end
            for (int i = 0; i < plen; i++) begin
                if ($urandom_range(0, 9) == 0) line.push_back(C_CR);
                else line.push_back(8'($urandom_range(32, 126)));
            end
            line.push_back(C_NL);
            issue_line(line);
        end
        wait_quiet();

        issue_line(str2q("Sabcdefghijklmnopqrstu\n"));
        @(negedge clk);
        @(negedge clk);
        check("mid_emit_active", isstring, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("emit_rst");
        chars_q.delete();
        err_q.delete();
        @(negedge clk);
        reset = 1'b0;
        issue_line(str2q("Sok\n"));
        wait_quiet();

        resp_delay = 1000;
        issue_line(str2q("Pabc\n"));
        t = 0;
        while (t < 100 && !(wait_st == 1 && !ispattern)) begin
            @(negedge clk);
            t++;
        end
        check("wait_res_reached", (t < 100) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        check("wait_res_busy", busy, 1);
        check("wait_res_in_ready", in_ready, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("wait_rst");
        chars_q.delete();
        err_q.delete();
        @(negedge clk);
        reset = 1'b0;
        resp_delay = 2;
        issue_line(str2q("Pxy\n"));
        issue_line(str2q("Sok\n"));
        wait_quiet();

        check("chars_drained", chars_q.size(), 0);
        check("errs_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
